// File: rtl/wbcon_pkg.sv
// Shared types and constants for the Wishbone console response path.
package wbcon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } ser_state_e;

  localparam logic [5:0]  HDR_MAGIC_DEFAULT = 6'h28;
  localparam int unsigned HDR_ERR_BIT       = 1;
  localparam int unsigned HDR_OP_BIT        = 0;

  // Frame header byte: {magic, err, op}.
  function automatic logic [7:0] make_hdr(input logic [5:0] magic,
                                          input logic       err,
                                          input logic       op);
    logic [7:0] h;
    h              = {magic, 2'b00};
    h[HDR_ERR_BIT] = err;
    h[HDR_OP_BIT]  = op;
    return h;
  endfunction

endpackage

// File: rtl/wbcon_resp_fifo.sv
// Response queue: synchronous FIFO with registered head outputs.
// A freshly written entry becomes visible on rd_valid/rd_data one cycle after
// the write; entries already queued stay visible back-to-back across pops.
module wbcon_resp_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             not_empty,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_adv;
  logic [CNT_W-1:0] count_q, count_old, count_d;
  logic             do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full       = (count_q == CNT_W'(DEPTH));
  assign not_empty  = (count_q != '0);
  assign do_wr      = wr_en & ~full;
  assign do_rd      = rd_en & rd_valid;
  assign rd_ptr_adv = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  // Entries that existed before this cycle's write, after this cycle's pop.
  assign count_old  = count_q - CNT_W'(do_rd);
  assign count_d    = count_old + CNT_W'(do_wr);

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      rd_ptr_q <= rd_ptr_adv;
      count_q  <= count_d;
      rd_valid <= (count_old != '0);
      rd_data  <= mem[rd_ptr_adv];
    end
  end

endmodule

// File: rtl/wbcon_resp_tx.sv
// Response-side framer: forwards requests to the executor, queues results and
// serialises each one as a header (+ data bytes for successful reads) on TX.
module wbcon_resp_tx
  import wbcon_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned RESP_DEPTH = 2,
  parameter logic [5:0]  HDR_MAGIC  = HDR_MAGIC_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_mreq_valid,
  input  logic                    i_mreq_op,
  output logic                    o_mreq_ready,
  output logic                    o_mreq_valid,
  input  logic                    i_mreq_ready,
  input  logic [8*WORD_BYTES-1:0] i_resp_data,
  input  logic                    i_resp_err,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy
);

  localparam int unsigned DATA_W = 8 * WORD_BYTES;
  localparam int unsigned ENT_W  = DATA_W + 2;
  localparam int unsigned CNT_W  = $clog2(WORD_BYTES) + 1;

  logic              q_full, q_not_empty, q_head_valid, q_pop;
  logic [ENT_W-1:0]  q_wr_data, q_head;
  logic              head_op, head_err;
  logic [DATA_W-1:0] head_data;

  ser_state_e        state_q, state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_ok_q, rd_ok_d;
  logic              hs, frame_done;

  // Request forwarding; full flag is the pre-pop value.
  assign o_mreq_valid = i_mreq_valid & ~q_full & ~i_rst;
  assign o_mreq_ready = o_mreq_valid & i_mreq_ready;
  assign q_wr_data    = {i_mreq_op, i_resp_err, i_resp_data};

  wbcon_resp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .wr_en     (o_mreq_ready),
    .wr_data   (q_wr_data),
    .rd_en     (q_pop),
    .full      (q_full),
    .not_empty (q_not_empty),
    .rd_valid  (q_head_valid),
    .rd_data   (q_head)
  );

  assign {head_op, head_err, head_data} = q_head;
  assign hs = tx_valid_q & i_tx_ready;

  // Serializer next state and TX datapath.
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rd_ok_d    = rd_ok_q;
    q_pop      = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_HDR: begin
        if (hs) begin
          if (rd_ok_q) begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            tx_data_d = shift_q[7:0];
            shift_d   = shift_q >> 8;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
            frame_done = 1'b1;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            tx_data_d = shift_q[7:0];
            shift_d   = shift_q >> 8;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Start the next frame immediately, or drop to idle.
    if ((state_q == ST_IDLE) || frame_done) begin
      if (q_head_valid) begin
        q_pop      = 1'b1;
        state_d    = ST_HDR;
        tx_valid_d = 1'b1;
        tx_data_d  = make_hdr(HDR_MAGIC, head_err, head_op);
        shift_d    = head_data;
        rd_ok_d    = head_op & ~head_err;
      end else begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  assign o_tx_valid = tx_valid_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = o_mreq_valid | q_not_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_wbcon_resp_tx.sv
// Directed bench for the console response framer.
module tb_wbcon_resp_tx;

  logic        clk;
  logic        i_rst;
  logic        i_mreq_valid, i_mreq_op, i_mreq_ready;
  logic [31:0] i_resp_data;
  logic        i_resp_err;
  logic        i_tx_ready;
  logic        o_mreq_ready, o_mreq_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, o_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] tx_q  [$];
  int         cyc_q [$];
  logic [7:0] exp_q [$];

  int         stall_viol = 0;
  int         stall_seen = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  wbcon_resp_tx dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_mreq_valid (i_mreq_valid),
    .i_mreq_op    (i_mreq_op),
    .o_mreq_ready (o_mreq_ready),
    .o_mreq_valid (o_mreq_valid),
    .i_mreq_ready (i_mreq_ready),
    .i_resp_data  (i_resp_data),
    .i_resp_err   (i_resp_err),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // TX monitor: log each handshake and watch hold-stability during stalls.
  always @(negedge clk) begin
    if (o_tx_valid && i_tx_ready && !i_rst) begin
      tx_q.push_back(o_tx_data);
      cyc_q.push_back(cyc);
    end
    if (i_rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stall_viol <= stall_viol + 1;
      if (o_tx_valid && !i_tx_ready) stall_seen <= stall_seen + 1;
      prev_stall <= o_tx_valid && !i_tx_ready;
      prev_data  <= o_tx_data;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (tx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (tx_q.size() >= n);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_mreq_valid = 1'b1; i_mreq_op = 1'b1; i_mreq_ready = 1'b1;
    i_resp_data = 32'hFFFF_FFFF; i_resp_err = 1'b0; i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    tick();
    total++; if (o_tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", o_tx_valid); end
    total++; if (o_tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", o_tx_data); end
    total++; if (o_mreq_valid !== 1'b0) begin bad++; $display("FAIL rst_mreq_valid got=%b exp=0", o_mreq_valid); end
    total++; if (o_mreq_ready !== 1'b0) begin bad++; $display("FAIL rst_mreq_ready got=%b exp=0", o_mreq_ready); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    drive_edge();
    i_rst = 1'b0; i_mreq_valid = 1'b0; i_mreq_ready = 1'b0;
    repeat (3) tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", o_busy); end
    total++; if (tx_q.size() != 0) begin bad++; $display("FAIL post_rst_no_tx got=%0d exp=0", tx_q.size()); end
  endtask

  task automatic test_read_ok();
    int c0;
    bit ok;
    tx_q.delete(); cyc_q.delete();
    exp_q = '{8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};
    drive_edge();
    c0 = cyc;
    i_mreq_valid = 1'b1; i_mreq_op = 1'b1; i_mreq_ready = 1'b1;
    i_resp_data = 32'h1122_3344; i_resp_err = 1'b0; i_tx_ready = 1'b1;
    tick();
    total++; if (o_mreq_ready !== 1'b1) begin bad++; $display("FAIL rd_mreq_ready got=%b exp=1", o_mreq_ready); end
    drive_edge();
    i_mreq_valid = 1'b0; i_mreq_ready = 1'b0; i_resp_data = 32'h0;
    wait_bytes(5, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_timeout got=%0d bytes exp=5", tx_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL rd_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    if (cyc_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (cyc_q[i] != c0 + 3 + i) begin bad++; $display("FAIL rd_timing%0d got=%0d exp=%0d", i, cyc_q[i], c0 + 3 + i); end
      end
    end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rd_busy_last got=%b exp=1", o_busy); end
    tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rd_busy_drop got=%b exp=0", o_busy); end
    total++; if (o_tx_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop got=%b exp=0", o_tx_valid); end
  endtask

  task automatic test_write_delayed();
    int pulses;
    bit ok;
    pulses = 0;
    tx_q.delete(); cyc_q.delete();
    drive_edge();
    i_mreq_valid = 1'b1; i_mreq_op = 1'b0; i_mreq_ready = 1'b0;
    i_resp_data = 32'hDEAD_0000; i_resp_err = 1'b0; i_tx_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_mreq_ready === 1'b1) pulses++;
      total++;
      if (o_mreq_ready !== i_mreq_ready) begin bad++; $display("FAIL wr_ready_coincide%0d got=%b exp=%b", k, o_mreq_ready, i_mreq_ready); end
      drive_edge();
      if (k == 4) i_mreq_ready = 1'b1;
      if (k == 5) begin i_mreq_valid = 1'b0; i_mreq_ready = 1'b0; end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL wr_pulses got=%0d exp=1", pulses); end
    wait_bytes(1, 20, ok);
    repeat (3) tick();
    total++; if (tx_q.size() != 1) begin bad++; $display("FAIL wr_nbytes got=%0d exp=1", tx_q.size()); end
    total++; if (tx_q.size() == 0 || tx_q[0] !== 8'hA0) begin bad++; $display("FAIL wr_hdr got=%h exp=a0", (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_errors();
    bit ok;
    tx_q.delete(); cyc_q.delete();
    drive_edge();
    i_mreq_valid = 1'b1; i_mreq_op = 1'b1; i_mreq_ready = 1'b1;
    i_resp_data = 32'hCAFE_F00D; i_resp_err = 1'b1; i_tx_ready = 1'b1;
    drive_edge();
    i_mreq_op = 1'b0; i_resp_data = 32'h0;
    drive_edge();
    i_mreq_valid = 1'b0; i_mreq_ready = 1'b0; i_resp_err = 1'b0;
    wait_bytes(2, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL err_timeout got=%0d bytes exp=2", tx_q.size()); end
    repeat (6) tick();
    total++; if (tx_q.size() != 2) begin bad++; $display("FAIL err_nbytes got=%0d exp=2", tx_q.size()); end
    total++; if (tx_q.size() < 1 || tx_q[0] !== 8'hA3) begin bad++; $display("FAIL err_rd_hdr got=%h exp=a3", (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    total++; if (tx_q.size() < 2 || tx_q[1] !== 8'hA2) begin bad++; $display("FAIL err_wr_hdr got=%h exp=a2", (tx_q.size() > 1) ? tx_q[1] : 8'hxx); end
    total++; if (cyc_q.size() < 2 || cyc_q[1] != cyc_q[0] + 1) begin bad++; $display("FAIL err_contig got=%0d exp=1", (cyc_q.size() > 1) ? cyc_q[1] - cyc_q[0] : -1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    tx_q.delete(); cyc_q.delete();
    exp_q = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04,
              8'hA1, 8'h11, 8'h12, 8'h13, 8'h14,
              8'hA1, 8'h21, 8'h22, 8'h23, 8'h24};
    drive_edge();
    i_tx_ready = 1'b0;
    i_mreq_valid = 1'b1; i_mreq_op = 1'b1; i_mreq_ready = 1'b1; i_resp_err = 1'b0;
    i_resp_data = 32'h0403_0201;
    tick();
    total++; if (o_mreq_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc1 got=%b exp=1", o_mreq_ready); end
    drive_edge();
    i_resp_data = 32'h1413_1211;
    tick();
    total++; if (o_mreq_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc2 got=%b exp=1", o_mreq_ready); end
    drive_edge();
    i_resp_data = 32'h2423_2221;
    tick();
    total++; if (o_mreq_valid !== 1'b0) begin bad++; $display("FAIL b2b_full_hold got=%b exp=0", o_mreq_valid); end
    total++; if (o_tx_valid !== 1'b0) begin bad++; $display("FAIL b2b_pre_frame got=%b exp=0", o_tx_valid); end
    drive_edge();
    tick();
    total++; if (o_mreq_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc3 got=%b exp=1", o_mreq_ready); end
    total++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA1) begin bad++; $display("FAIL b2b_frame_start got=%b/%h exp=1/a1", o_tx_valid, o_tx_data); end
    drive_edge();
    i_mreq_valid = 1'b0; i_mreq_ready = 1'b0;
    repeat (4) tick();
    total++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA1) begin bad++; $display("FAIL b2b_stalled got=%b/%h exp=1/a1", o_tx_valid, o_tx_data); end
    total++; if (o_mreq_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_req got=%b exp=0", o_mreq_valid); end
    drive_edge();
    i_tx_ready = 1'b1;
    wait_bytes(15, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d bytes exp=15", tx_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    total++; if (cyc_q.size() < 15 || cyc_q[14] != cyc_q[0] + 14) begin bad++; $display("FAIL b2b_bubbles got=%0d exp=14", (cyc_q.size() >= 15) ? cyc_q[14] - cyc_q[0] : -1); end
    repeat (2) tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_stall_toggle();
    int viol0, seen0, k;
    tx_q.delete(); cyc_q.delete();
    exp_q = '{8'hA1, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    viol0 = stall_viol; seen0 = stall_seen;
    drive_edge();
    i_tx_ready = 1'b0;
    i_mreq_valid = 1'b1; i_mreq_op = 1'b1; i_mreq_ready = 1'b1;
    i_resp_data = 32'hDEAD_BEEF; i_resp_err = 1'b0;
    drive_edge();
    i_mreq_valid = 1'b0; i_mreq_ready = 1'b0;
    k = 0;
    while (tx_q.size() < 5 && k < 60) begin
      drive_edge();
      i_tx_ready = ~i_tx_ready;
      k++;
    end
    i_tx_ready = 1'b1;
    repeat (3) tick();
    total++; if (tx_q.size() != 5) begin bad++; $display("FAIL tog_nbytes got=%0d exp=5", tx_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      total++;
      if (got !== exp_q[i]) begin bad++; $display("FAIL tog_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    total++; if (stall_viol != viol0) begin bad++; $display("FAIL tog_stable got=%0d exp=%0d", stall_viol, viol0); end
    total++; if (stall_seen <= seen0 + 2) begin bad++; $display("FAIL tog_stalls got=%0d exp>%0d", stall_seen - seen0, 2); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    tx_q.delete(); cyc_q.delete();
    drive_edge();
    i_tx_ready = 1'b1;
    i_mreq_valid = 1'b1; i_mreq_op = 1'b1; i_mreq_ready = 1'b1;
    i_resp_data = 32'h5566_7788; i_resp_err = 1'b0;
    drive_edge();
    i_mreq_valid = 1'b0; i_mreq_ready = 1'b0;
    wait_bytes(3, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstm_timeout got=%0d bytes exp=3", tx_q.size()); end
    i_rst = 1'b1;
    drive_edge();
    i_rst = 1'b0;
    tick();
    total++; if (o_tx_valid !== 1'b0) begin bad++; $display("FAIL rstm_valid got=%b exp=0", o_tx_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstm_busy got=%b exp=0", o_busy); end
    repeat (4) tick();
    total++; if (tx_q.size() != 3) begin bad++; $display("FAIL rstm_no_resume got=%0d exp=3", tx_q.size()); end
    total++; if (tx_q.size() < 3 || tx_q[2] !== 8'h77) begin bad++; $display("FAIL rstm_last_byte got=%h exp=77", (tx_q.size() > 2) ? tx_q[2] : 8'hxx); end
    drive_edge();
    i_mreq_valid = 1'b1; i_mreq_op = 1'b0; i_mreq_ready = 1'b1;
    drive_edge();
    i_mreq_valid = 1'b0; i_mreq_ready = 1'b0;
    wait_bytes(4, 20, ok);
    repeat (4) tick();
    total++; if (tx_q.size() != 4) begin bad++; $display("FAIL rstm_new_nbytes got=%0d exp=4", tx_q.size()); end
    total++; if (tx_q.size() < 4 || tx_q[3] !== 8'hA0) begin bad++; $display("FAIL rstm_new_hdr got=%h exp=a0", (tx_q.size() > 3) ? tx_q[3] : 8'hxx); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstm_end_busy got=%b exp=0", o_busy); end
  endtask

  initial begin
    i_rst = 1'b1; i_mreq_valid = 1'b0; i_mreq_op = 1'b0; i_mreq_ready = 1'b0;
    i_resp_data = 32'h0; i_resp_err = 1'b0; i_tx_ready = 1'b0;
    test_reset();
    test_read_ok();
    test_write_delayed();
    test_errors();
    test_back_to_back();
    test_stall_toggle();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbcon_resp_tx.md
Name: wbcon_resp_tx

Overview:
- Response-side framer for the Wishbone console.
- Accepts memory requests from the command parser and forwards them to the bus executor.
- Captures each completed result (read data, error flag) into a RESP_DEPTH-entry response queue.
- Serialises each result as a byte frame on the console TX stream.
- Generalises the single-byte, single-outstanding TX path: multi-byte words, error reporting, read/write framing, and request/transmit overlap.

Parameters:
- WORD_BYTES, 4: bytes per read-data word; legal range 1..8.
- RESP_DEPTH, 2: response queue entries; power of two, ≥1.
- HDR_MAGIC, 6'h28: bits [7:2] of every frame header byte.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high; single clock domain
- i_mreq_valid  in  1  upstream request valid
- i_mreq_op  in  1  1 = read, 0 = write; stable while i_mreq_valid
- o_mreq_ready  out  1  upstream request accepted
- o_mreq_valid  out  1  request to executor
- i_mreq_ready  in  1  executor done; result present this cycle
- i_resp_data  in  8*WORD_BYTES  read data, sampled with executor ack
- i_resp_err  in  1  bus error, sampled with executor ack
- o_tx_data  out  8  TX byte
- o_tx_valid  out  1  TX byte valid
- i_tx_ready  in  1  TX sink ready
- o_busy  out  1  request in flight, queue non-empty, or frame in progress

Behaviour:
- Reset: o_tx_valid=0, o_tx_data=0, o_mreq_valid=0, o_mreq_ready=0, o_busy=0. Queue emptied; serializer to IDLE. Reset mid-frame truncates the frame; no resume.
- Request forwarding (combinational):
  - o_mreq_valid = i_mreq_valid & queue_not_full.
  - o_mreq_ready = o_mreq_valid & i_mreq_ready.
  - Upstream ack and executor ack occur in the same cycle.
  - Full queue holds o_mreq_valid low; the request waits.
  - i_mreq_ready while o_mreq_valid=0 is ignored.
- Capture: on executor ack, write {op, err, data} to the queue. A new request may be acked the very next cycle (back-to-back).
- Simultaneous write and read on a full queue: the forwarding path uses the pre-read full flag, so the write is blocked that cycle.
- Frame format:
  - Header = {HDR_MAGIC, err, op}.
  - If op=1 and err=0, the header is followed by WORD_BYTES data bytes, LSB first.
  - Otherwise the frame is the header only.
- Serializer FSM:
  - IDLE: if queue non-empty, pop, load header → HDR.
  - HDR: on tx handshake, go to DATA (byte counter=0) if read-ok; else pop next entry → HDR, or → IDLE.
  - DATA: on handshake, counter+1. After the last byte, pop next entry → HDR, or → IDLE.
  - No idle cycle between consecutive frames.
- Stream rules:
  - o_tx_data/o_tx_valid are registered.
  - Once o_tx_valid=1, data holds stable until i_tx_ready.
  - Throughput is 1 byte/clk with i_tx_ready=1.
- Latency: executor ack at edge E with the serializer idle and queue empty → o_tx_valid=1 with the header after edge E+2, exactly.
- Byte counter is $clog2(WORD_BYTES)+1 bits wide; data shift is by 8 per byte. WORD_BYTES=1 gives a 2-byte read frame.
- o_busy = o_mreq_valid | queue_not_empty | (state≠IDLE).

Decomposition:
- Package wbcon_pkg holds:
  - serializer state enum (IDLE/HDR/DATA)
  - default HDR_MAGIC
  - header bit positions (ERR=1, OP=0)
- Sub-module wbcon_resp_fifo: synchronous FIFO, width 2+8*WORD_BYTES, depth RESP_DEPTH, registered outputs.

Test Plan:
- Read, no error, data 0x11223344, i_tx_ready=1 → TX bytes A1 44 33 22 11, contiguous; o_busy drops 1 cycle after the last byte.
- Write with executor ack delayed 5 cycles → single TX A0; exactly one o_mreq_ready pulse, coincident with the executor ack.
- Read with i_resp_err=1 → single TX A3, no data bytes. Write with err → A2.
- Three back-to-back reads with immediate executor ack and i_tx_ready=0 → two accepted (RESP_DEPTH=2); third holds o_mreq_valid low until the first frame starts draining. Then release ready → 15 bytes in order, no bubbles.
- i_tx_ready toggled 1/0 every cycle during a read frame → o_tx_data stable across stalls; byte order unchanged.
- Assert i_rst after 2 data bytes → next cycle o_tx_valid=0, o_busy=0. A new write then yields A0 only.
